audio_codec_if: RTL
===================

// Module: audio_codec_if
// PURPOSE
//  Serial audio port master for the board codec (left-justified format). Generates BCLK/LRCK,
//  serializes the effect block's output sample to DACDAT and deserializes ADCDAT into a parallel
//  sample. Issues the sample_req/sample_end strobes consumed by the effect blocks.
//  Mono: one sample per frame goes to both DAC channels; only the left ADC channel is returned.
// PARAMETERS
//  DATA_W     16  sample width, MSB first, two's complement
//  BCLK_DIV   4   clk cycles per BCLK half-period (legal >= 2)
//  SLOT_BITS  16  BCLK periods per channel slot (legal >= DATA_W; frame = 2*SLOT_BITS BCLKs)
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       synchronous active-low reset
//  sample_req    out  1       1-cycle pulse: drive audio_output, sampled >= 2*BCLK_DIV cycles later
//  audio_output  in   DATA_W  sample to play, loaded at left-slot start
//  sample_end    out  1       1-cycle pulse: audio_input holds a new left ADC sample
//  audio_input   out  DATA_W  last complete left ADC sample
//  aud_bclk      out  1       bit clock, clk/(2*BCLK_DIV)
//  aud_daclrck   out  1       frame clock, 1 = left slot
//  aud_adclrck   out  1       identical to aud_daclrck
//  aud_dacdat    out  1       serial DAC data
//  aud_adcdat    in   1       serial ADC data
// BEHAVIOUR
//  Reset values: aud_bclk=0, lrck=0, div_cnt=0, bit_cnt=SLOT_BITS-2.
//   Also: sample_req=0, sample_end=0, audio_input=0, aud_dacdat=0, shift/hold regs=0.
//   Reset wins over all events and may occur mid-frame. No partial-frame strobes are issued.
//  div_cnt counts 0..BCLK_DIV-1 and wraps. At the wrap, aud_bclk toggles.
//   Rise event = wrap with aud_bclk==0. Fall event = wrap with aud_bclk==1.
//  Fall event: if bit_cnt==SLOT_BITS-1, bit_cnt<=0 and lrck toggles; otherwise bit_cnt++.
//  sample_req<=1 on the fall event where lrck==0 and bit_cnt==SLOT_BITS-2. Otherwise sample_req<=0.
//   This is exactly one pulse per frame, one BCLK before the left slot.
//  DAC path, on each fall event:
//   - Starting left slot: dac_shift<=audio_output and dac_hold<=audio_output.
//   - Starting right slot: dac_shift<=dac_hold.
//   - Otherwise: dac_shift shifts left with 0 fill.
//   aud_dacdat = dac_shift MSB, so bits at or beyond DATA_W in a slot read 0.
//   audio_output is ignored except on the left-slot-start fall event.
//  ADC path, on each rise event with bit_cnt<DATA_W: adc_shift <= {adc_shift[DATA_W-2:0], aud_adcdat}.
//   Bits at or beyond DATA_W are discarded.
//  Capture: on the rise event with lrck==1 and bit_cnt==DATA_W-1:
//   - audio_input <= {adc_shift[DATA_W-2:0], aud_adcdat}
//   - sample_end <= 1 on the same edge, so audio_input is valid while sample_end is high.
//   Otherwise sample_end<=0. Right-slot data never reaches audio_input.
//   audio_input holds its value between captures.
//  Frame period = 4*SLOT_BITS*BCLK_DIV clk cycles. Both strobes recur at exactly this period.
//  All outputs are registered. aud_adclrck and aud_daclrck come from the same flop.
// TESTING (DATA_W=16, BCLK_DIV=2, SLOT_BITS=16)
//  1. Reset: reset_n low 10 cycles -> all outputs 0. After release, aud_bclk rises on edge 2 and falls on edge 4.
//     sample_req is high after edge 4. lrck goes 1 after edge 8.
//  2. DAC: audio_output=16'h7FFF -> left and right slots each shift out 0 followed by fifteen 1s.
//     Changing audio_output mid-frame does not alter the right slot.
//  3. ADC: drive 16'h8003 in the left slot and 16'h1234 in the right slot.
//     -> audio_input=16'h8003 with exactly one sample_end per frame; 16'h1234 never appears.
//  4. Loopback: tie aud_adcdat to aud_dacdat and answer sample_req with 16'hF629.
//     -> the next sample_end shows audio_input=16'hF629.
//  5. Timing: sample_req-to-sample_req and sample_end-to-sample_end spacing is exactly 128 clk over 8 frames.
//  6. Mid-frame reset: reset_n low for 1 cycle during left-slot bit 5.
//     -> the next cycle shows reset values and no sample_end for that frame. Timing then matches test 1.

Source files
------------

// File: rtl/audio_codec_if.sv
// +--------------------------------------------------------------------------+
// | audio_codec_if: left-justified serial audio port master (mono in/out).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module audio_codec_if #(
  parameter int DATA_W    = 16,
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              sample_req,
  input  logic [DATA_W-1:0] audio_output,
  output logic              sample_end,
  output logic [DATA_W-1:0] audio_input,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_adclrck,
  output logic              aud_dacdat,
  input  logic              aud_adcdat
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W = $clog2(SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] REQ_BIT   = CNT_W'(SLOT_BITS - 2);
  localparam logic [CNT_W-1:0] CAP_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W:0]   DATA_BITS = (CNT_W+1)'(DATA_W);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sample_req_q, sample_req_d;
  logic              sample_end_q, sample_end_d;
  logic [DATA_W-1:0] audio_input_q, audio_input_d;
  logic [DATA_W-1:0] dac_shift_q, dac_shift_d;
  logic [DATA_W-1:0] dac_hold_q, dac_hold_d;
  logic [DATA_W-2:0] adc_shift_q, adc_shift_d;

  logic              wrap;
  logic              rise_evt;
  logic              fall_evt;
  logic              slot_end;
  logic [DATA_W-1:0] adc_next;

  always_comb begin
    wrap     = (div_cnt_q == DIV_LAST);
    rise_evt = wrap && !bclk_q;
    fall_evt = wrap && bclk_q;
    slot_end = (bit_cnt_q == SLOT_LAST);
    // Only DATA_W-1 history bits are kept; the incoming bit completes the word.
    adc_next = {adc_shift_q, aud_adcdat};

    div_cnt_d     = wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d        = wrap ? !bclk_q : bclk_q;
    lrck_d        = lrck_q;
    bit_cnt_d     = bit_cnt_q;
    sample_req_d  = 1'b0;
    sample_end_d  = 1'b0;
    audio_input_d = audio_input_q;
    dac_shift_d   = dac_shift_q;
    dac_hold_d    = dac_hold_q;
    adc_shift_d   = adc_shift_q;

    if (fall_evt) begin
      sample_req_d = !lrck_q && (bit_cnt_q == REQ_BIT);
      if (slot_end) begin
        bit_cnt_d = '0;
        lrck_d    = !lrck_q;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      // The right slot replays the word latched at the left-slot start.
      if (slot_end && !lrck_q) begin
        dac_shift_d = audio_output;
        dac_hold_d  = audio_output;
      end else if (slot_end) begin
        dac_shift_d = dac_hold_q;
      end else begin
        dac_shift_d = {dac_shift_q[DATA_W-2:0], 1'b0};
      end
    end

    if (rise_evt) begin
      if ({1'b0, bit_cnt_q} < DATA_BITS) begin
        adc_shift_d = adc_next[DATA_W-2:0];
      end
      if (lrck_q && (bit_cnt_q == CAP_BIT)) begin
        audio_input_d = adc_next;
        sample_end_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      bit_cnt_q     <= REQ_BIT;
      sample_req_q  <= 1'b0;
      sample_end_q  <= 1'b0;
      audio_input_q <= '0;
      dac_shift_q   <= '0;
      dac_hold_q    <= '0;
      adc_shift_q   <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      bit_cnt_q     <= bit_cnt_d;
      sample_req_q  <= sample_req_d;
      sample_end_q  <= sample_end_d;
      audio_input_q <= audio_input_d;
      dac_shift_q   <= dac_shift_d;
      dac_hold_q    <= dac_hold_d;
      adc_shift_q   <= adc_shift_d;
    end
  end

  assign sample_req  = sample_req_q;
  assign sample_end  = sample_end_q;
  assign audio_input = audio_input_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_adclrck = lrck_q;
  assign aud_dacdat  = dac_shift_q[DATA_W-1];

endmodule

`default_nettype wire
